// File: rtl/acc_cpu_param.sv
// acc_cpu_param: parametrised accumulator CPU core.
// Memory lives outside the core behind a request/ready handshake; the core
// holds mem_addr/mem_rd/mem_wr/mem_wdata steady until mem_ready completes the
// request, so any number of wait states can be inserted.
// Instruction word: opcode in the top 4 bits, operand address in the low
// ADDR_W bits. DATA_W must be at least ADDR_W+4 so the two fields never overlap.
// Optional build macro ACC_CPU_SINGLE_STEP_EN adds a step input and a STEP
// wait state after every retired instruction.
//
// state  | meaning
// FETCH  | request M[pc]; on ready load ir and advance pc
// DECODE | execute register/branch ops, dispatch memory ops, catch HLT
// EXEC   | operand read (LDA/ADD/AND/XOR) or write (STA); retire on ready
// HALT   | stopped by HLT, no memory traffic, left only by reset
// STEP   | single-step build: idle until a step pulse, then FETCH
module acc_cpu_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
`ifdef ACC_CPU_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ac,
  output logic [DATA_W-1:0] ir,
  output logic              e_flag,
  output logic              halted,
  output logic              instr_done
);

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    HALT,
    STEP
  } state_t;

`ifdef ACC_CPU_SINGLE_STEP_EN
  localparam state_t RETIRE_STATE = STEP;
`else
  localparam state_t RETIRE_STATE = FETCH;
`endif

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_INC = 4'h8;
  localparam logic [3:0] OP_CLA = 4'h9;
  localparam logic [3:0] OP_CMA = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hB;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [DATA_W-1:0] ac_nxt;
  logic [DATA_W-1:0] ir_nxt;
  logic              e_nxt;
  logic              halted_nxt;
  logic              done_nxt;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W:0]   add_sum;

  assign opcode  = ir[DATA_W-1 -: 4];
  assign operand = ir[ADDR_W-1:0];
  assign add_sum = {1'b0, ac} + {1'b0, mem_rdata};

  // State and architectural registers; reset abandons any pending transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= '0;
      ac         <= '0;
      ir         <= '0;
      e_flag     <= 1'b0;
      halted     <= 1'b0;
      instr_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      ac         <= ac_nxt;
      ir         <= ir_nxt;
      e_flag     <= e_nxt;
      halted     <= halted_nxt;
      instr_done <= done_nxt;
    end
  end

  // Next-state, datapath updates and memory request outputs.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ac_nxt     = ac;
    ir_nxt     = ir;
    e_nxt      = e_flag;
    halted_nxt = halted;
    done_nxt   = 1'b0;
    mem_addr   = pc;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_wdata  = ac;

    case (state)
      FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_nxt    = mem_rdata;
          pc_nxt    = pc + ADDR_W'(1);
          state_nxt = DECODE;
        end
      end

      DECODE: begin
        case (opcode)
          OP_LDA, OP_STA, OP_ADD, OP_AND, OP_XOR: begin
            state_nxt = EXEC;
          end
          OP_HLT: begin
            halted_nxt = 1'b1;
            done_nxt   = 1'b1;
            state_nxt  = HALT;
          end
          default: begin
            // NOP and the unassigned opcodes C-F fall through with no effect.
            done_nxt  = 1'b1;
            state_nxt = RETIRE_STATE;
            case (opcode)
              OP_JMP: pc_nxt = operand;
              OP_JZ:  if (ac == '0) pc_nxt = operand;
              OP_INC: ac_nxt = ac + DATA_W'(1);
              OP_CLA: ac_nxt = '0;
              OP_CMA: ac_nxt = ~ac;
              default: ;
            endcase
          end
        endcase
      end

      EXEC: begin
        mem_addr = operand;
        if (opcode == OP_STA) mem_wr = 1'b1;
        else                  mem_rd = 1'b1;
        if (mem_ready) begin
          done_nxt  = 1'b1;
          state_nxt = RETIRE_STATE;
          case (opcode)
            OP_LDA: ac_nxt = mem_rdata;
            OP_ADD: {e_nxt, ac_nxt} = add_sum;
            OP_AND: ac_nxt = ac & mem_rdata;
            OP_XOR: ac_nxt = ac ^ mem_rdata;
            default: ;
          endcase
        end
      end

      HALT: begin
        state_nxt = HALT;
      end

`ifdef ACC_CPU_SINGLE_STEP_EN
      STEP: begin
        if (step) state_nxt = FETCH;
      end
`endif

      default: begin
        state_nxt = FETCH;
      end
    endcase

    // The state register may still hold EXEC during reset; never issue a request then.
    if (reset) begin
      mem_rd = 1'b0;
      mem_wr = 1'b0;
    end
  end

endmodule

// File: tb/tb_acc_cpu_param.sv
// Self-checking bench for acc_cpu_param with a 16-word memory model and a
// selectable mem_ready pattern (always, every 4th cycle, or manual).
module tb_acc_cpu_param;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] mem_addr, pc;
  logic          mem_rd, mem_wr, mem_ready, e_flag, halted, instr_done;
  logic [DW-1:0] mem_wdata, mem_rdata, ac, ir;
`ifdef ACC_CPU_SINGLE_STEP_EN
  logic          step = 1'b0;
`endif

  logic [15:0][7:0] mem;
  logic [15:0][7:0] load_img = '0;
  logic             load_req = 1'b0;
  int               ready_mode = 0;
  logic             man_ready = 1'b1;
  logic [31:0]      cyc = '0;
  int               done_cnt = 0;
  int               viol_cnt = 0;
  logic [3:0]       rd_log[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  acc_cpu_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock      (clock),
    .reset      (reset),
`ifdef ACC_CPU_SINGLE_STEP_EN
    .step       (step),
`endif
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .pc         (pc),
    .ac         (ac),
    .ir         (ir),
    .e_flag     (e_flag),
    .halted     (halted),
    .instr_done (instr_done)
  );

  assign mem_rdata = mem[mem_addr];
  assign mem_ready = (ready_mode == 0) ? 1'b1 :
                     (ready_mode == 1) ? (cyc[1:0] == 2'd3) : man_ready;

  always @(negedge clock) cyc <= cyc + 32'd1;

  // Memory model: program load, accepted writes, and a log of accepted read addresses.
  logic ready_q = 1'b0;
  logic reset_q = 1'b1;
  always @(posedge clock) begin
    ready_q <= mem_ready;
    reset_q <= reset;
    if (load_req) mem <= load_img;
    else if (!reset && mem_wr && mem_ready) mem[mem_addr] <= mem_wdata;
    if (!reset && mem_rd && mem_ready) rd_log.push_back(mem_addr);
  end

  // Handshake watcher: counts retire pulses and protocol violations.
  logic          prev_req = 1'b0;
  logic          prev_rd, prev_wr;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata;
  always @(negedge clock) begin
    if (!reset && instr_done) done_cnt++;
    if (!reset && mem_rd && mem_wr) viol_cnt++;
    if (!reset && prev_req && !ready_q && !reset_q) begin
      if (mem_rd !== prev_rd || mem_wr !== prev_wr || mem_addr !== prev_addr ||
          (mem_wr && mem_wdata !== prev_wdata))
        viol_cnt++;
    end
    prev_req   = !reset && (mem_rd || mem_wr);
    prev_rd    = mem_rd;
    prev_wr    = mem_wr;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start(input logic [15:0][7:0] img);
    @(negedge clock);
    reset    = 1'b1;
    load_img = img;
    load_req = 1'b1;
    repeat (2) @(negedge clock);
    load_req = 1'b0;
    reset    = 1'b0;
  endtask

  typedef struct {
    logic [15:0][7:0] img;
    bit               slow;
    logic [7:0]       exp_ac;
    logic             exp_e;
    logic [3:0]       exp_pc;
    int               exp_cycles;
    int               exp_done;
    logic [3:0]       chk_addr;
    logic [7:0]       chk_val;
  } vec_t;

  localparam int NV = 6;
  vec_t vec[NV];

  logic [15:0][7:0] p_main, p_br, p_log, p_carry, p_nocarry, p_wrap;
  int               cycles, base, lbase, viol_base;
  logic [3:0]       br_seq[5];

  initial begin
    p_main = '0;
    p_main[0] = 8'h1E; p_main[1] = 8'h3F; p_main[2] = 8'h2D; p_main[3] = 8'hB0;
    p_main[14] = 8'hF0; p_main[15] = 8'h25;
    p_br = '0;
    p_br[0] = 8'h90; p_br[1] = 8'h75; p_br[5] = 8'h80; p_br[6] = 8'h72; p_br[7] = 8'hB0;
    p_log = '0;
    p_log[0] = 8'h1A; p_log[1] = 8'h4B; p_log[2] = 8'h5C; p_log[3] = 8'hA0;
    p_log[4] = 8'h00; p_log[5] = 8'hC0; p_log[6] = 8'h80; p_log[7] = 8'hB0;
    p_log[10] = 8'h3C; p_log[11] = 8'h0F; p_log[12] = 8'hFF;
    p_carry = '0;
    p_carry[0] = 8'h1E; p_carry[1] = 8'h3F; p_carry[2] = 8'h80; p_carry[3] = 8'h90;
    p_carry[4] = 8'h80; p_carry[5] = 8'hB0; p_carry[14] = 8'hFF; p_carry[15] = 8'h01;
    p_nocarry = '0;
    p_nocarry[0] = 8'h1E; p_nocarry[1] = 8'h3F; p_nocarry[2] = 8'h3F; p_nocarry[3] = 8'hB0;
    p_nocarry[14] = 8'hFF; p_nocarry[15] = 8'h01;
    p_wrap = '0;
    p_wrap[0] = 8'h6F; p_wrap[15] = 8'h00;

    //          img        slow  ac     e     pc     cyc done addr   val
    vec[0] = '{p_main,    1'b0, 8'h15, 1'b1, 4'd4,  11,  4,  4'd13, 8'h15};
    vec[1] = '{p_main,    1'b1, 8'h15, 1'b1, 4'd4,  0,   4,  4'd13, 8'h15};
    vec[2] = '{p_br,      1'b0, 8'h01, 1'b0, 4'd8,  10,  5,  4'd5,  8'h80};
    vec[3] = '{p_log,     1'b0, 8'h0D, 1'b0, 4'd8,  19,  8,  4'd10, 8'h3C};
    vec[4] = '{p_carry,   1'b0, 8'h01, 1'b1, 4'd6,  14,  6,  4'd14, 8'hFF};
    vec[5] = '{p_nocarry, 1'b1, 8'h01, 1'b0, 4'd4,  0,   4,  4'd15, 8'h01};

    br_seq[0] = 4'd0; br_seq[1] = 4'd1; br_seq[2] = 4'd5; br_seq[3] = 4'd6; br_seq[4] = 4'd7;

    // Table-driven whole-program runs.
    for (int t = 0; t < NV; t++) begin
      ready_mode = vec[t].slow ? 1 : 0;
      viol_base  = viol_cnt;
      start(vec[t].img);
      base   = done_cnt;
      cycles = 0;
      while (!halted && cycles < 400) begin
        @(posedge clock); #1;
        cycles++;
      end
      check($sformatf("v%0d_halted", t), {31'd0, halted}, 32'd1);
      if (vec[t].exp_cycles != 0)
        check($sformatf("v%0d_cycles", t), cycles, vec[t].exp_cycles);
      repeat (3) @(negedge clock);
      check($sformatf("v%0d_done_pulses", t), done_cnt - base, vec[t].exp_done);
      check($sformatf("v%0d_ac", t), {24'd0, ac}, {24'd0, vec[t].exp_ac});
      check($sformatf("v%0d_e", t), {31'd0, e_flag}, {31'd0, vec[t].exp_e});
      check($sformatf("v%0d_pc", t), {28'd0, pc}, {28'd0, vec[t].exp_pc});
      check($sformatf("v%0d_mem", t), {24'd0, mem[vec[t].chk_addr]}, {24'd0, vec[t].chk_val});
      check($sformatf("v%0d_halt_idle", t), {31'd0, mem_rd | mem_wr | instr_done}, 32'd0);
      check($sformatf("v%0d_handshake", t), viol_cnt - viol_base, 32'd0);
    end

    // Branch program: fetch address sequence.
    ready_mode = 0;
    start(p_br);
    lbase = rd_log.size();
    repeat (15) @(negedge clock);
    check("br_fetch_count", rd_log.size() - lbase, 32'd5);
    if (rd_log.size() >= lbase + 5)
      for (int i = 0; i < 5; i++)
        check($sformatf("br_fetch%0d", i), {28'd0, rd_log[lbase+i]}, {28'd0, br_seq[i]});

    // PC wrap: JMP 15, NOP at 15, then fetch from 0.
    start(p_wrap);
    lbase = rd_log.size();
    @(posedge clock); #1; check("wrap_pc_e1", {28'd0, pc}, 32'd1);
    @(posedge clock); #1; check("wrap_pc_e2", {28'd0, pc}, 32'd15);
    @(posedge clock); #1; check("wrap_pc_e3", {28'd0, pc}, 32'd0);
    check("wrap_ir_nop", {24'd0, ir}, 32'd0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("wrap_log_count", rd_log.size() - lbase, 32'd3);
    if (rd_log.size() >= lbase + 3) begin
      check("wrap_fetch1", {28'd0, rd_log[lbase+1]}, 32'd15);
      check("wrap_fetch2", {28'd0, rd_log[lbase+2]}, 32'd0);
    end

    // Reset while LDA waits in EXEC.
    ready_mode = 2;
    man_ready  = 1'b1;
    start(p_main);
    @(negedge clock);
    man_ready = 1'b0;
    @(negedge clock);
    check("exec_rd", {31'd0, mem_rd}, 32'd1);
    check("exec_addr", {28'd0, mem_addr}, 32'd14);
    @(negedge clock);
    check("exec_hold_addr", {28'd0, mem_addr}, 32'd14);
    reset = 1'b1;
    #2;
    check("rst_no_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_no_wr", {31'd0, mem_wr}, 32'd0);
    @(posedge clock); #1;
    check("rst_regs", {pc, ac, ir, e_flag, halted, instr_done}, 32'd0);
    check("rst_addr", {28'd0, mem_addr}, 32'd0);
    @(negedge clock);
    reset     = 1'b0;
    man_ready = 1'b1;
    #1;
    check("refetch_rd", {31'd0, mem_rd}, 32'd1);
    check("refetch_addr", {28'd0, mem_addr}, 32'd0);
    @(posedge clock); #1;
    check("refetch_ir", {24'd0, ir}, 32'h1E);

`ifdef ACC_CPU_SINGLE_STEP_EN
    // Single-step gating.
    ready_mode = 0;
    step = 1'b0;
    start(p_main);
    base = done_cnt;
    repeat (20) @(negedge clock);
    check("step_first_only", done_cnt - base, 32'd1);
    check("step_idle_rd", {31'd0, mem_rd | mem_wr}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step = 1'b1;
      @(negedge clock);
      step = 1'b0;
      repeat (12) @(negedge clock);
      check($sformatf("step_pulse%0d", k), done_cnt - base, 1 + k);
    end
    check("step_halted", {31'd0, halted}, 32'd1);
    check("step_ac", {24'd0, ac}, 32'h15);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_cpu_param.md
Name: acc_cpu_param

Overview:
- Parametrised accumulator CPU core; next generation of the fixed 8-bit-data / 4-bit-address CPU.
- Data and address widths are set by parameters.
- Memory sits outside the core, behind a request/ready handshake that allows wait states.
- Instruction completion and halt are reported to the bench/top level.

Parameters:
- DATA_W, 8, data/instruction word width; must satisfy DATA_W >= ADDR_W+4.
- ADDR_W, 4, address width; PC and AR are ADDR_W bits.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_addr  out  ADDR_W  memory address.
- mem_rd  out  1  read request; held until accepted.
- mem_wr  out  1  write request; held until accepted.
- mem_wdata  out  DATA_W  write data (AC).
- mem_rdata  in  DATA_W  read data; valid when mem_ready=1.
- mem_ready  in  1  completes the pending request this cycle.
- pc  out  ADDR_W  program counter.
- ac  out  DATA_W  accumulator.
- ir  out  DATA_W  instruction register.
- e_flag  out  1  carry flag.
- halted  out  1  core stopped by HLT.
- instr_done  out  1  one-cycle pulse at instruction retire.

Behaviour:
- Reset (sync, active-high):
  - pc=0, ac=0, ir=0, e_flag=0, halted=0, instr_done=0, state=FETCH.
  - mem_rd=mem_wr=0 while reset=1.
  - Reset mid-transaction abandons the transaction; the core refetches from address 0.
- Instruction format: opcode=ir[DATA_W-1:DATA_W-4], operand address=ir[ADDR_W-1:0], other bits ignored.
- Opcodes:
  - 0 NOP.
  - 1 LDA: AC=M[a].
  - 2 STA: M[a]=AC.
  - 3 ADD: {E,AC}=AC+M[a].
  - 4 AND: AC&=M[a].
  - 5 XOR: AC^=M[a].
  - 6 JMP: PC=a.
  - 7 JZ: if AC==0 then PC=a.
  - 8 INC: AC=AC+1, E unchanged.
  - 9 CLA: AC=0.
  - A CMA: AC=~AC.
  - B HLT.
  - C-F: treated as NOP.
- FSM states: FETCH, DECODE, EXEC, HALT.
- FETCH:
  - mem_addr=pc, mem_rd=1.
  - On mem_ready: ir<=mem_rdata, pc<=pc+1 (mod 2^ADDR_W), go to DECODE.
- DECODE:
  - Register/branch ops (0,6-F) execute here, pulse instr_done, then go to FETCH.
  - HLT sets halted=1 and goes to HALT.
  - Memory ops (1-5) go to EXEC.
- EXEC:
  - mem_addr=operand; mem_rd=1 (ops 1,3,4,5) or mem_wr=1 with mem_wdata=ac (op 2).
  - On mem_ready: apply result, pulse instr_done, go to FETCH.
- HALT: absorbing state; only reset leaves it. mem_rd=mem_wr=0.
- mem_addr, mem_rd, mem_wr, mem_wdata are combinational from state/pc/ir/ac.
- mem_rd and mem_wr are never both 1.
- Request signals stay stable while mem_ready=0.
- Latency with mem_ready tied high: register ops 2 cycles, memory ops 3 cycles.
- Each wait cycle adds one cycle to the instruction.
- Arithmetic is modulo 2^DATA_W. E is written only by ADD.
- JMP/JZ target overrides the fetch increment; pc wraps from 2^ADDR_W-1 to 0.
- instr_done pulses for exactly one cycle per retired instruction, including NOP/JZ-not-taken; HLT also pulses it.

Optional Feature:
- Macro: ACC_CPU_SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - After each instr_done the FSM waits in STEP state.
  - A cycle with step=1 moves it to FETCH; no fetch occurs otherwise.
  - HLT goes to HALT directly.
  - Reset goes to FETCH, so the first instruction runs without a step.
- Undefined: no step port; FETCH follows retirement immediately.

Test Plan:
- Program run, mem_ready=1. Memory: M0=0x1E, M1=0x3F, M2=0x2D, M3=0xB0, M14=0xF0, M15=0x25.
  - Required: ac=0x15, e_flag=1, M13=0x15, pc=4, halted=1.
  - Exactly 11 cycles from reset release to halted; 4 instr_done pulses.
- Same program with mem_ready asserted only every 4th cycle -> identical final state; mem_rd/mem_wr/mem_addr held stable during waits.
- Branch: M0=0x90 CLA, M1=0x75 JZ 5, M5=0x80 INC, M6=0x72 JZ 2, M7=0xB0 HLT.
  - Required: pc sequence 0,1,5,6,7; ac=1; halted with pc=8.
- Wrap: M0=0x6F JMP 15, M15=0x00 NOP, M0 re-fetched.
  - Required: pc goes 15 then 0; the first fetch after the NOP reads address 0.
- Reset during EXEC of LDA with mem_ready=0: reset for 1 cycle.
  - Required: mem_rd=0 during reset; all outputs 0 next cycle; next fetch at address 0.
- With ACC_CPU_SINGLE_STEP_EN: step=0 -> exactly one instruction retires, then no mem_rd; each single-cycle step pulse retires exactly one more instruction.
